// File: rtl/addr_decoder_lat.sv
// Multi-channel N-to-2^N address decoder with a shared transparent-low address
// latch, registered active-low outputs and per-channel level / one-shot pulse modes.
module addr_decoder_lat #(
    parameter int ADDR_W    = 2,
    parameter int CH        = 2,
    parameter int PULSE_LEN = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cen,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          le_n,
    input  logic [CH-1:0]                 g1,
    input  logic [CH-1:0]                 g2_n,
    input  logic [CH-1:0]                 mode,
    output logic [CH*(2**ADDR_W)-1:0]     o_n,
    output logic [CH-1:0]                 busy
);

    localparam int D  = 2 ** ADDR_W;
    localparam int CW = $clog2(PULSE_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [D-1:0]      dec_n;

    always_comb begin
        addr_d = addr_q;
        if (cen && !le_n) begin
            addr_d = addr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Decoded pattern is always built from the latched address, never the live bus.
    assign dec_n = ~(D'(1) << addr_q);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        state_t            state_q, state_d;
        logic              mode_q, mode_d;
        logic              en_prev_q, en_prev_d;
        logic              busy_q, busy_d;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic [ADDR_W-1:0] sel_q, sel_d;
        logic [D-1:0]      o_n_q, o_n_d;
        logic              en;

        assign en = g1[c] & ~g2_n[c];

        // NOTE: every next-state signal gets a hold default first, so no latch is inferred.
        always_comb begin
            state_d   = state_q;
            mode_d    = mode_q;
            en_prev_d = en_prev_q;
            busy_d    = busy_q;
            cnt_d     = cnt_q;
            sel_d     = sel_q;
            o_n_d     = o_n_q;

            if (cen) begin
                en_prev_d = en;
                case (state_q)
                    ST_IDLE: begin
                        mode_d = mode[c];
                        if (!mode_q) begin
                            o_n_d = en ? dec_n : '1;
                        end else if (en && !en_prev_q) begin
                            sel_d   = addr_q;
                            cnt_d   = CW'(PULSE_LEN - 1);
                            o_n_d   = dec_n;
                            state_d = ST_FIRE;
                        end else begin
                            o_n_d = '1;
                        end
                    end
                    ST_FIRE: begin
                        // Strobe bit was frozen at entry; en and addr_q are ignored until expiry.
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CW'(1);
                        end else begin
                            o_n_d   = '1;
                            state_d = en ? ST_HOLD : ST_IDLE;
                        end
                    end
                    ST_HOLD: begin
                        o_n_d = '1;
                        if (!en) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: begin
                        o_n_d   = '1;
                        state_d = ST_IDLE;
                    end
                endcase
                busy_d = (state_d != ST_IDLE);
            end
        end

        // NOTE: all per-channel registers, counter and select included, take a defined reset value.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q   <= ST_IDLE;
                mode_q    <= 1'b0;
                en_prev_q <= 1'b0;
                busy_q    <= 1'b0;
                cnt_q     <= '0;
                sel_q     <= '0;
                o_n_q     <= '1;
            end else begin
                state_q   <= state_d;
                mode_q    <= mode_d;
                en_prev_q <= en_prev_d;
                busy_q    <= busy_d;
                cnt_q     <= cnt_d;
                sel_q     <= sel_d;
                o_n_q     <= o_n_d;
            end
        end

        assign o_n[c*D +: D] = o_n_q;
        assign busy[c]       = busy_q;
    end

endmodule

// File: tb/tb_addr_decoder_lat.sv
// Self-checking bench for addr_decoder_lat: directed scenarios plus randomized
// traffic, all compared every cycle against an event-level reference model.
module tb_addr_decoder_lat;

    localparam int ADDR_W    = 2;
    localparam int CH        = 2;
    localparam int PULSE_LEN = 4;
    localparam int D         = 2 ** ADDR_W;
    localparam int W         = CH * D;

    logic              clk = 1'b0;
    logic              reset;
    logic              cen;
    logic [ADDR_W-1:0] addr;
    logic              le_n;
    logic [CH-1:0]     g1;
    logic [CH-1:0]     g2_n;
    logic [CH-1:0]     mode;
    logic [W-1:0]      o_n;
    logic [CH-1:0]     busy;

    int n_cmp = 0;
    int n_bad = 0;

    addr_decoder_lat #(
        .ADDR_W   (ADDR_W),
        .CH       (CH),
        .PULSE_LEN(PULSE_LEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .cen  (cen),
        .addr (addr),
        .le_n (le_n),
        .g1   (g1),
        .g2_n (g2_n),
        .mode (mode),
        .o_n  (o_n),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Reference model: strobe tracked as "how many enabled edges it has been low".
    bit                m_strobing [CH];
    bit                m_waiting  [CH];
    int                m_low_edges[CH];
    bit                m_mode     [CH];
    bit                m_prev_en  [CH];
    logic [D-1:0]      m_out      [CH];
    logic [ADDR_W-1:0] m_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = '0;
        for (int c = 0; c < CH; c++) begin
            m_strobing[c]  = 1'b0;
            m_waiting[c]   = 1'b0;
            m_low_edges[c] = 0;
            m_mode[c]      = 1'b0;
            m_prev_en[c]   = 1'b0;
            m_out[c]       = '1;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            bit en;
            bit was_quiet;
            en        = g1[c] && !g2_n[c];
            was_quiet = !m_strobing[c] && !m_waiting[c];
            if (m_strobing[c]) begin
                if (m_low_edges[c] < PULSE_LEN) begin
                    m_low_edges[c]++;
                end else begin
                    m_strobing[c] = 1'b0;
                    m_waiting[c]  = en;
                    m_out[c]      = '1;
                end
            end else if (m_waiting[c]) begin
                if (!en) m_waiting[c] = 1'b0;
                m_out[c] = '1;
            end else if (!m_mode[c]) begin
                m_out[c] = en ? ~(D'(1) << m_addr) : '1;
            end else if (en && !m_prev_en[c]) begin
                m_strobing[c]  = 1'b1;
                m_low_edges[c] = 1;
                m_out[c]       = ~(D'(1) << m_addr);
            end else begin
                m_out[c] = '1;
            end
            if (was_quiet) m_mode[c] = mode[c];
            m_prev_en[c] = en;
        end
        if (!le_n) m_addr = addr;
    endtask

    function automatic logic [W-1:0] model_o_n();
        logic [W-1:0] v;
        for (int c = 0; c < CH; c++) v[c*D +: D] = m_out[c];
        return v;
    endfunction

    function automatic logic [CH-1:0] model_busy();
        logic [CH-1:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_strobing[c] || m_waiting[c];
        return v;
    endfunction

    // One clk period: model advances on enabled edges, outputs sampled at negedge.
    task automatic cycle();
        @(posedge clk);
        if (!reset && cen) model_step();
        @(negedge clk);
        check("o_n_model", o_n, model_o_n());
        check("busy_model", busy, model_busy());
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        check("o_n_async_reset", o_n, 8'hFF);
        check("busy_async_reset", busy, 2'b00);
        model_reset();
    endtask

    initial begin
        int lows_hi;
        int lows_lo;

        // Reset with all inputs active
        reset = 1'b1; cen = 1'b1; addr = 2'd3; le_n = 1'b0;
        g1 = 2'b11; g2_n = 2'b00; mode = 2'b11;
        model_reset();
        repeat (3) cycle();
        check("reset_o_n", o_n, 8'hFF);
        check("reset_busy", busy, 2'b00);
        g1 = 2'b00; g2_n = 2'b11; mode = 2'b00; addr = 2'd0;
        reset = 1'b0;
        cycle();
        check("post_release_o_n", o_n, 8'hFF);

        // Level mode on ch0: two edges from addr to output
        g1 = 2'b01; g2_n = 2'b10; le_n = 1'b0; addr = 2'd2;
        cycle();
        cycle();
        check("level_addr2", o_n, 8'hFB);
        le_n = 1'b1; addr = 2'd1;
        cycle();
        cycle();
        check("level_latch_hold", o_n, 8'hFB);
        g2_n = 2'b11;
        cycle();
        check("level_disable", o_n, 8'hFF);

        // Pulse mode on ch1 with addr_q = 3
        g1 = 2'b00; mode = 2'b10; addr = 2'd3; le_n = 1'b0;
        cycle();
        le_n = 1'b1;
        cycle();
        g1 = 2'b10; g2_n = 2'b01;
        cycle();
        check("pulse_first_edge", o_n, 8'h7F);
        check("pulse_busy_on", busy, 2'b10);
        lows_hi = 1;
        repeat (7) begin
            cycle();
            if (o_n[7] == 1'b0) lows_hi++;
        end
        check("pulse_len", lows_hi, PULSE_LEN);
        check("pulse_hold_busy", busy, 2'b10);
        g1 = 2'b00;
        cycle();
        check("pulse_busy_release", busy, 2'b00);

        // Re-trigger attempts and address change during FIRE
        g1 = 2'b10;
        cycle();
        lows_hi = (o_n[7] == 1'b0) ? 1 : 0;
        lows_lo = 0;
        g1 = 2'b00;
        cycle();
        if (o_n[7] == 1'b0) lows_hi++;
        g1 = 2'b10; addr = 2'd0; le_n = 1'b0;
        repeat (6) begin
            cycle();
            if (o_n[7] == 1'b0) lows_hi++;
            if (o_n[4] == 1'b0) lows_lo++;
        end
        le_n = 1'b1;
        check("retrig_single_strobe", lows_hi, PULSE_LEN);
        check("retrig_no_moved_bit", lows_lo, 0);
        g1 = 2'b00;
        cycle();
        g1 = 2'b10;
        cycle();
        check("rearm_new_strobe", o_n, 8'hEF);
        repeat (4) cycle();
        g1 = 2'b00;
        cycle();

        // Sparse clock enable; mode dropped to level mid-pulse
        lows_lo = 0;
        for (int i = 0; i < 24; i++) begin
            cen = (i % 3 == 0);
            if (i == 0)  g1 = 2'b10;
            if (i == 5)  mode = 2'b00;
            if (i == 14) g1 = 2'b00;
            if (i == 20) g1 = 2'b10;
            cycle();
            if (i < 20 && o_n[4] == 1'b0) lows_lo++;
        end
        check("cen_scaled_strobe", lows_lo, 3 * PULSE_LEN);
        check("level_after_pulse", o_n, 8'hEF);
        cen = 1'b1;
        g1 = 2'b00;
        cycle();

        // Asynchronous reset in FIRE, then a fresh full strobe
        mode = 2'b10;
        cycle();
        cycle();
        g1 = 2'b10;
        cycle();
        cycle();
        async_reset_pulse();
        g1 = 2'b00;
        cycle();
        reset = 1'b0;
        cycle();
        g1 = 2'b10;
        lows_lo = 0;
        repeat (8) begin
            cycle();
            if (o_n[4] == 1'b0) lows_lo++;
        end
        check("post_reset_strobe", lows_lo, PULSE_LEN);
        g1 = 2'b00;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cen  = ($urandom_range(0, 3) != 0);
            le_n = $urandom_range(0, 1);
            addr = ADDR_W'($urandom);
            if ($urandom_range(0, 3) == 0) g1   = CH'($urandom);
            if ($urandom_range(0, 3) == 0) g2_n = CH'($urandom);
            if ($urandom_range(0, 15) == 0) mode = CH'($urandom);
            if ($urandom_range(0, 79) == 0) begin
                async_reset_pulse();
                cycle();
                reset = 1'b0;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
